encoder_active_high_seq: RTL and testbench

Sequential active-high encoder: the inverse direction of the team's active-high binary-to-one-hot decoder. It accepts a multi-hot request vector and serialises it into a stream of binary indices, one per accepted beat, lowest set bit first. Each index `i` corresponds to bit `i`, the same mapping the decoder produces for `1<<sel`. It sits between request sources (interrupt lines, grant vectors) and any consumer that needs one binary select at a time.

---
 rtl/encoder_pkg.sv | 14 +
 rtl/priority_encoder_lsb.sv | 14 +
 rtl/encoder_active_high_seq.sv | 44 ++++
 tb/tb_encoder_active_high_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: FSM state enum, bit-scan helpers (lowest_set_index, is_single_bit) and their maximum vector width
package encoder_pkg;
  localparam int MAX_SIZE = 64;
  localparam int MAX_SEL = 6;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic [MAX_SEL-1:0] lowest_set_index(input logic [MAX_SIZE-1:0] vec);
    lowest_set_index = '0;
    for (int i = MAX_SIZE - 1; i >= 0; i--)
      if (vec[i]) lowest_set_index = MAX_SEL'(i);
  endfunction
  function automatic logic is_single_bit(input logic [MAX_SIZE-1:0] vec);
    return vec != '0 && (vec & (vec - MAX_SIZE'(1))) == '0;
  endfunction
endpackage

// File: rtl/priority_encoder_lsb.sv
// priority_encoder_lsb: combinational lowest-set-bit encoder; vec in, idx (binary index) and any (vec nonzero) out
module priority_encoder_lsb
  import encoder_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  localparam int SEL_SIZE = $clog2(DATA_SIZE)
) (
  input  logic [DATA_SIZE-1:0] vec,
  output logic [SEL_SIZE-1:0]  idx,
  output logic                 any
);
  assign idx = SEL_SIZE'(lowest_set_index(MAX_SIZE'(vec)));
  assign any = |vec;
endmodule

// File: rtl/encoder_active_high_seq.sv
// encoder_active_high_seq: serialises a multi-hot vector into LSB-first indices; clk_in/rst_in, data_in+load_in/ready_out in, sel_out+valid_out+last_out/ready_in out, zero_out pulse on all-zero load
module encoder_active_high_seq
  import encoder_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  localparam int SEL_SIZE = $clog2(DATA_SIZE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 load_in,
  output logic                 ready_out,
  output logic [SEL_SIZE-1:0]  sel_out,
  output logic                 valid_out,
  output logic                 last_out,
  input  logic                 ready_in,
  output logic                 zero_out
);
  state_t state, state_nx;
  logic [DATA_SIZE-1:0] pending;
  logic [SEL_SIZE-1:0] low;
  logic any, transfer, load;
  priority_encoder_lsb #(.DATA_SIZE(DATA_SIZE)) u_pe (.vec(pending), .idx(low), .any(any));
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      pending <= '0;
      zero_out <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= load ? data_in : transfer ? pending & (pending - DATA_SIZE'(1)) : pending;
      zero_out <= load && data_in == '0;
    end
  end
  always_comb state_nx = load ? (data_in != '0 ? EMIT : IDLE) : (transfer && last_out) ? IDLE : state;
  always_comb begin
    valid_out = state == EMIT && any;
    sel_out = valid_out ? low : '0;
    last_out = valid_out && is_single_bit(MAX_SIZE'(pending));
    transfer = valid_out && ready_in;
    ready_out = state == IDLE || (transfer && last_out);
    load = load_in && ready_out;
  end
endmodule

// File: tb/tb_encoder_active_high_seq.sv
// tb_encoder_active_high_seq: scoreboard bench for encoder_active_high_seq at DATA_SIZE 4 and 5
module tb_encoder_active_high_seq;
  logic clk = 0, rst = 1, ready_in = 1, load4 = 0, load5 = 0;
  logic [3:0] data4 = '0;
  logic [4:0] data5 = '0;
  logic rdy4, v4, l4, z4, rdy5, v5, l5, z5;
  logic [1:0] s4;
  logic [2:0] s5;
  int checks = 0, errors = 0;
  int q4[$], q5[$], vq4[$], vq5[$];
  int acc4 = 0, acc5 = 0;
  always #5 clk = ~clk;
  encoder_active_high_seq #(.DATA_SIZE(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .data_in(data4), .load_in(load4), .ready_out(rdy4),
    .sel_out(s4), .valid_out(v4), .last_out(l4), .ready_in(ready_in), .zero_out(z4));
  encoder_active_high_seq #(.DATA_SIZE(5)) dut5 (
    .clk_in(clk), .rst_in(rst), .data_in(data5), .load_in(load5), .ready_out(rdy5),
    .sel_out(s5), .valid_out(v5), .last_out(l5), .ready_in(ready_in), .zero_out(z5));
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_beats(input int v, input int n);
    int hi = -1;
    for (int i = 0; i < n; i++) if (v[i]) hi = i;
    for (int i = 0; i < n; i++)
      if (v[i]) begin
        if (n == 4) q4.push_back(i * 2 + int'(i == hi));
        else q5.push_back(i * 2 + int'(i == hi));
      end
    if (v != 0) begin
      if (n == 4) vq4.push_back(v);
      else vq5.push_back(v);
    end
  endtask
  always @(negedge clk) begin
    if (v4 && ready_in) begin
      if (q4.size() == 0) check("beat4_unexpected", int'(s4), -1);
      else check("beat4", int'(s4) * 2 + int'(l4), q4.pop_front());
      acc4 |= 1 << s4;
      if (l4) begin
        check("or4", acc4, vq4.size() == 0 ? -1 : vq4.pop_front());
        acc4 = 0;
      end
    end
    if (rst) acc4 = 0;
  end
  always @(negedge clk) begin
    if (v5 && ready_in) begin
      if (q5.size() == 0) check("beat5_unexpected", int'(s5), -1);
      else check("beat5", int'(s5) * 2 + int'(l5), q5.pop_front());
      acc5 |= 1 << s5;
      if (l5) begin
        check("or5", acc5, vq5.size() == 0 ? -1 : vq5.pop_front());
        acc5 = 0;
      end
    end
    if (rst) acc5 = 0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int v, n;
    tick();
    tick();
    check("rst_ready", rdy4, 1);
    check("rst_valid", v4, 0);
    check("rst_sel", s4, 0);
    check("rst_last", l4, 0);
    check("rst_zero", z4, 0);
    rst = 0;
    expect_beats(4'b1011, 4);
    data4 = 4'b1011;
    load4 = 1;
    tick();
    load4 = 0;
    check("t1_valid", v4, 1);
    check("t1_sel0", s4, 0);
    tick();
    check("t1_sel1", s4, 1);
    tick();
    check("t1_sel3", s4, 3);
    check("t1_last", l4, 1);
    check("t1_ready_last", rdy4, 1);
    tick();
    check("t1_idle", v4, 0);
    expect_beats(4'b1000, 4);
    ready_in = 0;
    data4 = 4'b1000;
    load4 = 1;
    tick();
    load4 = 0;
    for (int i = 0; i < 3; i++) begin
      check("t2_sel", s4, 3);
      check("t2_valid", v4, 1);
      check("t2_last", l4, 1);
      check("t2_ready", rdy4, 0);
      tick();
    end
    ready_in = 1;
    #1;
    check("t2_ready_comb", rdy4, 1);
    tick();
    check("t2_idle", v4, 0);
    check("t2_idle_ready", rdy4, 1);
    data4 = 4'b0000;
    load4 = 1;
    tick();
    load4 = 0;
    check("t3_zero", z4, 1);
    check("t3_valid", v4, 0);
    check("t3_ready", rdy4, 1);
    tick();
    check("t3_zero_off", z4, 0);
    check("t3_valid_off", v4, 0);
    expect_beats(4'b0110, 4);
    data4 = 4'b0110;
    load4 = 1;
    tick();
    load4 = 0;
    check("t4_sel1", s4, 1);
    tick();
    check("t4_sel2", s4, 2);
    check("t4_last", l4, 1);
    expect_beats(4'b0001, 4);
    data4 = 4'b0001;
    load4 = 1;
    #1;
    check("t4_ready_b2b", rdy4, 1);
    tick();
    load4 = 0;
    check("t4_nogap", v4, 1);
    check("t4_sel0", s4, 0);
    check("t4_last0", l4, 1);
    tick();
    check("t4_idle", v4, 0);
    q4.push_back(0);
    data4 = 4'b1111;
    load4 = 1;
    tick();
    load4 = 0;
    check("t5_sel0", s4, 0);
    rst = 1;
    tick();
    rst = 0;
    check("t5_valid_rst", v4, 0);
    check("t5_ready_rst", rdy4, 1);
    expect_beats(4'b0100, 4);
    data4 = 4'b0100;
    load4 = 1;
    tick();
    load4 = 0;
    check("t5_sel2", s4, 2);
    check("t5_last2", l4, 1);
    tick();
    check("t5_idle", v4, 0);
    for (int k = 0; k < 24; k++) begin
      v = int'($urandom_range(0, 31));
      expect_beats(v & 15, 4);
      expect_beats(v, 5);
      data4 = 4'(v);
      data5 = 5'(v);
      ready_in = 1;
      load4 = 1;
      load5 = 1;
      tick();
      load4 = 0;
      load5 = 0;
      check("rnd_zero4", z4, int'((v & 15) == 0));
      check("rnd_zero5", z5, int'(v == 0));
      n = 0;
      while ((v4 || v5) && n < 100) begin
        ready_in = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      ready_in = 1;
      check("rnd_timeout", int'(n < 100), 1);
      check("rnd_left4", q4.size(), 0);
      check("rnd_left5", q5.size(), 0);
    end
    check("vec_left4", vq4.size(), 0);
    check("vec_left5", vq5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
